// File: rtl/his_readout_fsm_pkg.sv
// his_readout_fsm_pkg: shared state encoding and default widths for the histogram readout block
package his_readout_fsm_pkg;
    localparam int PIXEL_NUM_PER_RAM = 3;
    localparam int NP = 4;
    localparam int CNT_W_DEF = 8;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPT, S_SEND, S_DONE} state_t;
endpackage

// File: rtl/his_readout_fsm_peak_tracker.sv
// peak_tracker: running maximum of one pixel's bin stream; ties keep the earliest bin
module peak_tracker #(
    parameter int BIN_AW = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              i_clr,
    input  logic              i_cap,
    input  logic [BIN_AW-1:0] i_bin,
    input  logic [CNT_W-1:0]  i_cnt,
    output logic [BIN_AW-1:0] o_bin,
    output logic [CNT_W-1:0]  o_cnt
);
    logic [BIN_AW-1:0] r_bin;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (!res || i_clr) begin
            r_bin <= '0;
            r_cnt <= '0;
        end else if (i_cap && i_cnt > r_cnt) begin
            r_bin <= i_bin;
            r_cnt <= i_cnt;
        end
    end

    assign o_bin = r_bin;
    assign o_cnt = r_cnt;
endmodule

// File: rtl/his_readout_fsm.sv
// his_readout_fsm: streams histogram RAM bins as {pix,bin,cnt} beats, tracks the
// per-pixel peak bin and optionally zeroes each bin once it has been handed off.
module his_readout_fsm
    import his_readout_fsm_pkg::*;
#(
    parameter int PIX_NUM = PIXEL_NUM_PER_RAM,
    parameter int BIN_AW  = NP,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PIX_W   = 2
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      start,
    input  logic                      clrAfterRd,
    output logic                      busy,
    output logic                      done,
    output logic                      rdEn,
    output logic [PIX_W+BIN_AW-1:0]   ramAddr,
    input  logic [CNT_W-1:0]          rdData,
    output logic                      wrEn,
    output logic [CNT_W-1:0]          wrData,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [PIX_W-1:0]          outPix,
    output logic [BIN_AW-1:0]         outBin,
    output logic [CNT_W-1:0]          outCnt,
    output logic [PIX_NUM*BIN_AW-1:0] peakBin,
    output logic [PIX_NUM*CNT_W-1:0]  peakCnt,
    output logic                      peakValid
);
    state_t                    r_state;
    logic                      r_clr, r_busy, r_done, r_rdEn, r_outValid, r_peakValid;
    logic [PIX_W-1:0]          r_pix, r_outPix;
    logic [BIN_AW-1:0]         r_bin, r_outBin;
    logic [CNT_W-1:0]          r_outCnt;
    logic [PIX_NUM*BIN_AW-1:0] r_peakBin;
    logic [PIX_NUM*CNT_W-1:0]  r_peakCnt;
    logic                      w_hs, w_last_bin, w_last_pix, w_commit, w_trk_clr;
    logic [BIN_AW-1:0]         w_pk_bin;
    logic [CNT_W-1:0]          w_pk_cnt;

    assign w_hs       = (r_state == S_SEND) && outReady;
    assign w_last_bin = &r_bin;
    assign w_last_pix = r_pix == PIX_W'(PIX_NUM - 1);
    assign w_commit   = w_hs && w_last_bin;
    assign w_trk_clr  = w_commit || (r_state == S_IDLE && start);

    peak_tracker #(.BIN_AW(BIN_AW), .CNT_W(CNT_W)) u_peak (
        .clk   (clk),
        .res   (res),
        .i_clr (w_trk_clr),
        .i_cap (r_state == S_CAPT),
        .i_bin (r_bin),
        .i_cnt (rdData),
        .o_bin (w_pk_bin),
        .o_cnt (w_pk_cnt)
    );

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state     <= S_IDLE;
            r_clr       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rdEn      <= 1'b0;
            r_outValid  <= 1'b0;
            r_peakValid <= 1'b0;
            r_pix       <= '0;
            r_bin       <= '0;
            r_outPix    <= '0;
            r_outBin    <= '0;
            r_outCnt    <= '0;
            r_peakBin   <= '0;
            r_peakCnt   <= '0;
        end else begin
            r_rdEn <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_state     <= S_FETCH;
                    r_pix       <= '0;
                    r_bin       <= '0;
                    r_clr       <= clrAfterRd;
                    r_peakValid <= 1'b0;
                    r_rdEn      <= 1'b1;
                    r_busy      <= 1'b1;
                end
                S_FETCH: r_state <= S_CAPT;
                S_CAPT: begin
                    r_outCnt   <= rdData;
                    r_outPix   <= r_pix;
                    r_outBin   <= r_bin;
                    r_outValid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: if (outReady) begin
                    r_outValid <= 1'b0;
                    // the tracker already holds this pixel's last bin from CAPT
                    for (int p = 0; p < PIX_NUM; p++)
                        if (w_last_bin && r_pix == PIX_W'(p)) begin
                            r_peakBin[p*BIN_AW +: BIN_AW] <= w_pk_bin;
                            r_peakCnt[p*CNT_W +: CNT_W]   <= w_pk_cnt;
                        end
                    if (w_last_bin && w_last_pix) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_peakValid <= 1'b1;
                    end else begin
                        r_bin   <= r_bin + 1'b1;
                        r_pix   <= w_last_bin ? r_pix + 1'b1 : r_pix;
                        r_rdEn  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rdEn      = r_rdEn;
    assign ramAddr   = {r_pix, r_bin};
    assign wrEn      = w_hs && r_clr;
    assign wrData    = '0;
    assign outValid  = r_outValid;
    assign outPix    = r_outPix;
    assign outBin    = r_outBin;
    assign outCnt    = r_outCnt;
    assign peakBin   = r_peakBin;
    assign peakCnt   = r_peakCnt;
    assign peakValid = r_peakValid;
endmodule

// File: tb/tb_his_readout_fsm.sv
// tb_his_readout_fsm: directed checks of the histogram readout against a behavioural RAM
module tb_his_readout_fsm;
    logic        clk, res, start, clrAfterRd, outReady;
    logic        busy, done, rdEn, wrEn, outValid, peakValid;
    logic [5:0]  ramAddr;
    logic [7:0]  rdData, wrData, outCnt;
    logic [1:0]  outPix;
    logic [3:0]  outBin;
    logic [11:0] peakBin;
    logic [23:0] peakCnt;
    logic [69:0] w_all;
    logic [7:0]  mem [64];
    logic [7:0]  img [64];
    logic        ld;
    int          n_chk, n_pass;

    his_readout_fsm dut (
        .clk(clk), .res(res), .start(start), .clrAfterRd(clrAfterRd),
        .busy(busy), .done(done), .rdEn(rdEn), .ramAddr(ramAddr),
        .rdData(rdData), .wrEn(wrEn), .wrData(wrData), .outValid(outValid),
        .outReady(outReady), .outPix(outPix), .outBin(outBin), .outCnt(outCnt),
        .peakBin(peakBin), .peakCnt(peakCnt), .peakValid(peakValid)
    );

    assign w_all = {busy, done, rdEn, ramAddr, wrEn, wrData, outValid, outPix,
                    outBin, outCnt, peakBin, peakCnt, peakValid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld) mem <= img;
        else if (wrEn) mem[ramAddr] <= wrData;
        if (rdEn) rdData <= mem[ramAddr];
    end

    task automatic load_img(input bit tie);
        for (int i = 0; i < 64; i++) img[i] = (i < 16) ? 8'(i) : 8'd0;
        if (tie) begin
            img[18] = 8'd100;
            img[20] = 8'd200;
            img[25] = 8'd200;
            img[39] = 8'd50;
            img[40] = 8'd60;
        end
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic run_pass(input bit clr, input bit stall, input int start_at, output int done_cyc);
        int cyc, nb, st, nwr, first_v, bad;
        logic [5:0] a;
        clrAfterRd = clr;
        start = 1'b1;
        outReady = 1'b1;
        cyc = 0; nb = 0; st = 0; nwr = 0; first_v = -1; bad = 0; done_cyc = -1;
        while (cyc < 1500 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start = (cyc == start_at);
            if (cyc == 1) begin
                n_chk++;
                if ({rdEn, busy} !== 2'b11) $display("FAIL fetch_c1: rdEn,busy=%b expected 11", {rdEn, busy});
                else n_pass++;
            end
            outReady = !(stall && nb % 3 == 2 && st < 5);
            #1;
            if (rdEn && wrEn) bad++;
            if (wrEn) begin
                nwr++;
                if (!(outValid && outReady)) bad++;
            end
            if (outValid) begin
                if (first_v < 0) first_v = cyc;
                if (nb > 47) bad++;
                else begin
                    a = 6'(nb);
                    n_chk++;
                    if ({outPix, outBin, outCnt} !== {a, img[nb]})
                        $display("FAIL beat%0d: pix/bin/cnt=%h expected %h", nb, {outPix, outBin, outCnt}, {a, img[nb]});
                    else n_pass++;
                    if (outReady) begin
                        if (wrEn !== clr || (clr && ramAddr !== a)) bad++;
                        nb++;
                        st = 0;
                    end else st++;
                end
            end
            if (done) done_cyc = cyc;
        end
        n_chk++;
        if (done_cyc < 0) $display("FAIL done_timeout: no done within %0d cycles expected a done pulse", cyc);
        else n_pass++;
        n_chk++;
        if (nb !== 48) $display("FAIL beat_count: %0d expected 48", nb);
        else n_pass++;
        n_chk++;
        if (nwr !== (clr ? 48 : 0)) $display("FAIL wr_count: %0d expected %0d", nwr, clr ? 48 : 0);
        else n_pass++;
        n_chk++;
        if (bad !== 0) $display("FAIL ram_strobes: %0d bad strobe cycles expected 0", bad);
        else n_pass++;
        n_chk++;
        if (first_v !== 3) $display("FAIL first_valid: cycle %0d expected 3", first_v);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({done, busy, peakValid} !== 3'b001) $display("FAIL after_done: done,busy,peakValid=%b expected 001", {done, busy, peakValid});
        else n_pass++;
    endtask

    task automatic test_reset;
        res = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (w_all !== 70'd0) $display("FAIL reset_outputs: %h expected 0", w_all);
        else n_pass++;
        res = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp;
        int dc;
        load_img(1'b0);
        run_pass(1'b0, 1'b0, 0, dc);
        n_chk++;
        if (dc !== 145) $display("FAIL ramp_done_cycle: %0d expected 145", dc);
        else n_pass++;
        n_chk++;
        if ({peakBin, peakCnt} !== {12'h00F, 24'h00000F}) $display("FAIL ramp_peaks: %h expected %h", {peakBin, peakCnt}, {12'h00F, 24'h00000F});
        else n_pass++;
    endtask

    task automatic test_tie;
        int dc;
        load_img(1'b1);
        run_pass(1'b0, 1'b0, 0, dc);
        n_chk++;
        if ({peakBin, peakCnt} !== {12'h84F, 24'h3CC80F}) $display("FAIL tie_peaks: %h expected %h", {peakBin, peakCnt}, {12'h84F, 24'h3CC80F});
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int dc;
        load_img(1'b1);
        run_pass(1'b0, 1'b1, 0, dc);
        n_chk++;
        if (dc !== 225) $display("FAIL stall_done_cycle: %0d expected 225", dc);
        else n_pass++;
        n_chk++;
        if ({peakBin, peakCnt} !== {12'h84F, 24'h3CC80F}) $display("FAIL stall_peaks: %h expected %h", {peakBin, peakCnt}, {12'h84F, 24'h3CC80F});
        else n_pass++;
    endtask

    task automatic test_clear;
        int dc, nz;
        load_img(1'b1);
        run_pass(1'b1, 1'b0, 0, dc);
        n_chk++;
        if ({peakBin, peakCnt} !== {12'h84F, 24'h3CC80F}) $display("FAIL clr_peaks: %h expected %h", {peakBin, peakCnt}, {12'h84F, 24'h3CC80F});
        else n_pass++;
        nz = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 8'd0) nz++;
        n_chk++;
        if (nz !== 0) $display("FAIL clr_ram: %0d nonzero bins expected 0", nz);
        else n_pass++;
        for (int i = 0; i < 64; i++) img[i] = 8'd0;
        run_pass(1'b0, 1'b0, 0, dc);
        n_chk++;
        if ({peakBin, peakCnt} !== 36'd0) $display("FAIL zero_peaks: %h expected 0", {peakBin, peakCnt});
        else n_pass++;
    endtask

    task automatic test_busy_start;
        int dc;
        load_img(1'b1);
        run_pass(1'b0, 1'b0, 20, dc);
        n_chk++;
        if (dc !== 145) $display("FAIL busy_start_done_cycle: %0d expected 145", dc);
        else n_pass++;
        n_chk++;
        if ({peakBin, peakCnt} !== {12'h84F, 24'h3CC80F}) $display("FAIL busy_start_peaks: %h expected %h", {peakBin, peakCnt}, {12'h84F, 24'h3CC80F});
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int cyc, act;
        load_img(1'b1);
        clrAfterRd = 1'b0;
        outReady = 1'b1;
        start = 1'b1;
        cyc = 0;
        @(negedge clk);
        start = 1'b0;
        while (!outValid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        n_chk++;
        if (outValid !== 1'b1) $display("FAIL mid_reach_send: outValid=%b expected 1", outValid);
        else n_pass++;
        res = 1'b0;
        @(negedge clk);
        n_chk++;
        if (w_all !== 70'd0) $display("FAIL mid_reset_outputs: %h expected 0", w_all);
        else n_pass++;
        res = 1'b1;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdEn || wrEn || busy || outValid || peakValid) act++;
        end
        n_chk++;
        if (act !== 0) $display("FAIL mid_reset_quiet: %0d active cycles expected 0", act);
        else n_pass++;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        res = 1'b0;
        start = 1'b0;
        clrAfterRd = 1'b0;
        outReady = 1'b1;
        ld = 1'b0;
        test_reset;
        test_ramp;
        test_tie;
        test_backpressure;
        test_clear;
        test_busy_start;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
